aes_cipher_core: RTL and testbench

- Iterative AES-128 encryption datapath that consumes the flat 1408-bit round-key schedule produced by the key-expansion stage.
- Encrypts one 128-bit block with one round per clock, reusing the existing subBytes cell plus ShiftRows/MixColumns logic.
- Sits directly downstream of key expansion.
- Uses a valid/ready handshake on input and output so the surrounding datapath can stall either side.

---
 rtl/aes_cipher_core.sv | 180 ++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// AES-128 iterative encryption core: one round per clock over a flat,
// externally held round-key schedule, valid/ready on both sides.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a block; in_ready high
// ROUND  | applying rounds 1..Nr, one per edge, keys read live
// DONE   | ciphertext presented; waits for out_ready
module aes_cipher_core #(
    parameter int Nb   = 128,
    parameter int Nr   = 10,
    parameter int WORD = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Nb-1:0]          plain_in,
    input  logic [Nb*(Nr+1)-1:0]   key_schedule,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Nb-1:0]          cipher_out,
    output logic                   busy,
    output logic [3:0]             round_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits at bit offset 8*(255-x) == {~x, 3'b000}.
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD-1:0] mix_column(input logic [WORD-1:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [Nb-1:0] sub_bytes(input logic [Nb-1:0] s);
        logic [Nb-1:0] o;
        o = '0;
        for (int i = 0; i < Nb / 8; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte k is s[127-8k -: 8]; column c holds bytes 4c..4c+3, row r = k % 4.
    function automatic logic [Nb-1:0] shift_rows(input logic [Nb-1:0] s);
        logic [Nb-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[Nb-1-8*(4*c+r) -: 8] = s[Nb-1-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [Nb-1:0] mix_columns(input logic [Nb-1:0] s);
        logic [Nb-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[Nb-1-WORD*c -: WORD] = mix_column(s[Nb-1-WORD*c -: WORD]);
        end
        return o;
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [Nb-1:0] blk_q, blk_d;
    logic [3:0]    round_idx_q, round_idx_d;
    logic [Nb-1:0] cipher_q, cipher_d;

    logic [Nb-1:0] rk_sel;
    logic [Nb-1:0] sr_out;
    logic [Nb-1:0] mid_out;
    logic [Nb-1:0] final_out;

    // Round datapath: key picked live from the schedule by the round counter.
    always_comb begin
        rk_sel    = key_schedule[Nb*int'(round_idx_q) +: Nb];
        sr_out    = shift_rows(sub_bytes(blk_q));
        mid_out   = mix_columns(sr_out) ^ rk_sel;
        final_out = sr_out ^ rk_sel;
    end

    // Next-state, state-register and round-counter control.
    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        round_idx_d = round_idx_q;
        cipher_d    = cipher_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d       = plain_in ^ key_schedule[Nb-1:0];
                    round_idx_d = 4'd1;
                    fsm_d       = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_idx_q == LAST_ROUND) begin
                    blk_d       = final_out;
                    cipher_d    = final_out;
                    round_idx_d = 4'd0;
                    fsm_d       = ST_DONE;
                end else begin
                    blk_d       = mid_out;
                    round_idx_d = round_idx_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                round_idx_d = 4'd0;
            end
        endcase
    end

    // State flops; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            blk_q       <= '0;
            round_idx_q <= 4'd0;
            cipher_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            round_idx_q <= round_idx_d;
            cipher_q    <= cipher_d;
        end
    end

    assign in_ready   = (fsm_q == ST_IDLE);
    assign out_valid  = (fsm_q == ST_DONE);
    assign busy       = (fsm_q == ST_ROUND) || (fsm_q == ST_DONE);
    assign cipher_out = cipher_q;
    assign round_idx  = round_idx_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core: known-answer vectors plus handshake,
// back-pressure, collision, reset-abort and idle-stability sequences.
module tb_aes_cipher_core;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   plain_in;
    logic [1407:0]  key_schedule;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   cipher_out;
    logic           busy;
    logic [3:0]     round_idx;

    int n_vec = 0;
    int n_err = 0;

    aes_cipher_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plain_in     (plain_in),
        .key_schedule (key_schedule),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cipher_out   (cipher_out),
        .busy         (busy),
        .round_idx    (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    // ---------------- reference key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] o;
        o = v;
        for (int i = 0; i < n; i++) o = {o[6:0], o[7]};
        return o;
    endfunction

    // S-box from first principles: GF(2^8) inverse then the affine map.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block end to end, checking the per-edge round counter and handshake.
    task automatic run_block(input string name, input logic [127:0] key,
                             input logic [127:0] pt, input logic [127:0] ct,
                             input bit bp);
        int w;
        key_schedule = expand_key(key);
        plain_in     = pt;
        out_ready    = !bp;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk({name, " in_ready before accept"}, in_ready, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({name, " busy after accept"}, busy, 1);
        chk({name, " round_idx after accept"}, round_idx, 1);
        chk({name, " in_ready after accept"}, in_ready, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("%s round_idx after E%0d", name, k), round_idx, (k < 10) ? k + 1 : 0);
            chk($sformatf("%s out_valid after E%0d", name, k), out_valid, (k == 10) ? 1 : 0);
        end
        chk({name, " cipher_out"}, cipher_out, ct);
        chk({name, " busy in DONE"}, busy, 1);
        chk({name, " in_ready in DONE"}, in_ready, 0);
        if (bp) begin
            for (int k = 0; k < 20; k++) begin
                tick();
                chk($sformatf("%s hold out_valid c%0d", name, k), out_valid, 1);
                chk($sformatf("%s hold cipher_out c%0d", name, k), cipher_out, ct);
                chk($sformatf("%s hold in_ready c%0d", name, k), in_ready, 0);
            end
            out_ready = 1'b1;
        end
        tick();
        chk({name, " out_valid after handshake"}, out_valid, 0);
        chk({name, " in_ready after handshake"}, in_ready, 1);
        chk({name, " busy after handshake"}, busy, 0);
        chk({name, " cipher_out retained"}, cipher_out, ct);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " in_ready"}, in_ready, 1);
        chk({name, " out_valid"}, out_valid, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " round_idx"}, round_idx, 0);
        chk({name, " cipher_out"}, cipher_out, 0);
    endtask

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_AB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_AB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_AB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_ZZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        vec_t vecs [3];
        int   cnt;
        bit   got_a;
        bit   done;

        vecs[0] = '{name: "fips_c1",   key: K_C1,   pt: P_C1,   ct: C_C1};
        vecs[1] = '{name: "fips_appb", key: K_AB,   pt: P_AB,   ct: C_AB};
        vecs[2] = '{name: "zero_kp",   key: '0,     pt: '0,     ct: C_ZZ};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        plain_in     = '0;
        key_schedule = '0;
        #1;
        chk_reset_vals("reset async");
        repeat (3) tick();
        chk_reset_vals("reset held");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("after release");

        // Known-answer vectors with immediate consumer.
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b0);
        end

        // Consumer stalls for 20 cycles after completion.
        run_block("backpressure", K_AB, P_AB, C_AB, 1'b1);

        // Collision: in_valid held high, second block queued behind the first.
        key_schedule = expand_key(K_AB);
        plain_in     = P_AB;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        tick();
        chk("coll accept A busy", busy, 1);
        plain_in = P_C1;
        cnt   = 0;
        got_a = 1'b0;
        done  = 1'b0;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
            if (out_valid && !got_a) begin
                chk("coll cipher A", cipher_out, C_AB);
                got_a = 1'b1;
                key_schedule = expand_key(K_C1);
            end
            if (cnt == 11) chk("coll in_ready on idle cycle", in_ready, 1);
            if (busy && round_idx == 4'd1) done = 1'b1;
        end
        chk("coll A completed", got_a, 1);
        chk("coll accept spacing", cnt, 12);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 15) begin
            tick();
            cnt++;
        end
        chk("coll B out_valid", out_valid, 1);
        chk("coll cipher B", cipher_out, C_C1);
        tick();
        chk("coll B handshake", out_valid, 0);

        // Reset asserted in the middle of a block.
        key_schedule = expand_key(K_C1);
        plain_in     = P_AB;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (round_idx != 4'd5 && cnt < 15) begin
            tick();
            cnt++;
        end
        chk("midreset reached round 5", round_idx, 5);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset immediate");
        repeat (2) tick();
        chk_reset_vals("midreset held");
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("midreset no out_valid c%0d", k), out_valid, 0);
        end
        run_block("after_reset_c1", K_C1, P_C1, C_C1, 1'b0);

        // Idle with out_ready toggling and no input.
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            out_ready = k[0];
            tick();
            chk($sformatf("idle out_valid c%0d", k), out_valid, 0);
            chk($sformatf("idle in_ready c%0d", k), in_ready, 1);
            chk($sformatf("idle round_idx c%0d", k), round_idx, 0);
            chk($sformatf("idle cipher_out c%0d", k), cipher_out, C_C1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
